// File: rtl/alu_cmd_sequencer_if.sv
// Command/result handshake bundle between instruction source, sequencer and ALU.
// Optional ALU_FLAGS_EN adds the res_zero/res_neg status signals.
interface alu_cmd_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_acc;
    logic [11:0]      alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [WIDTH-1:0] acc;
    logic             busy;
`ifdef ALU_FLAGS_EN
    logic             res_zero;
    logic             res_neg;
`endif

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_result, res_ready,
        input  cmd_ready, alu_sel, alu_a, alu_b, res_valid, res_data, acc, busy
`ifdef ALU_FLAGS_EN
        , input res_zero, res_neg
`endif
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, alu_result, res_ready,
        output cmd_ready, alu_sel, alu_a, alu_b, res_valid, res_data, acc, busy
`ifdef ALU_FLAGS_EN
        , output res_zero, res_neg
`endif
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the combinational ALU: decode, operand hold, result capture.
// Define ALU_FLAGS_EN to add registered res_zero/res_neg flags.
module alu_cmd_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ALU_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    alu_cmd_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] LAT = 4'(ALU_LAT);

    state_t           state, state_nx;
    logic [3:0]       cnt;
    logic [11:0]      sel_q;
    logic [WIDTH-1:0] a_q, b_q, res_q, acc_q;
    logic [11:0]      dec;
    logic             accept, capture, is_clear;
`ifdef ALU_FLAGS_EN
    logic             zero_q, neg_q;
`endif

    function automatic logic [11:0] decode(input logic [3:0] op);
        case (op)
            4'b0000: decode = 12'h001;
            4'b0001: decode = 12'h002;
            4'b0010: decode = 12'h004;
            4'b0011: decode = 12'h008;
            4'b0100: decode = 12'h010;
            4'b0101: decode = 12'h020;
            4'b0110: decode = 12'h040;
            4'b1000: decode = 12'h080;
            4'b1001: decode = 12'h100;
            4'b1010: decode = 12'h200;
            4'b1011: decode = 12'h400;
            default: decode = 12'h800;
        endcase
    endfunction

    assign dec      = decode(bus.cmd_op);
    assign is_clear = dec[11];
    assign accept   = (state == IDLE) && bus.cmd_valid;
    assign capture  = (state == EXEC) && (cnt == 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.cmd_valid) state_nx = is_clear ? DONE : EXEC;
            EXEC: if (capture)       state_nx = DONE;
            DONE: if (bus.res_ready) state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            sel_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            acc_q  <= '0;
`ifdef ALU_FLAGS_EN
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_q <= bus.cmd_use_acc ? acc_q : bus.cmd_a;
            b_q <= bus.cmd_b;
            if (is_clear) begin
                // CLEAR completes at the accepting edge; the ALU is never selected.
                sel_q  <= '0;
                res_q  <= '0;
                acc_q  <= '0;
`ifdef ALU_FLAGS_EN
                zero_q <= 1'b1;
                neg_q  <= 1'b0;
`endif
            end else begin
                sel_q <= dec;
                cnt   <= LAT;
            end
        end else if (state == EXEC) begin
            cnt <= cnt - 4'd1;
            if (capture) begin
                sel_q  <= '0;
                res_q  <= bus.alu_result;
                acc_q  <= bus.alu_result;
`ifdef ALU_FLAGS_EN
                zero_q <= (bus.alu_result == '0);
                neg_q  <= bus.alu_result[WIDTH-1];
`endif
            end
        end
    end

    // cmd_ready is masked by rst so every output reads 0 while reset is held.
    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign bus.res_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.alu_sel   = sel_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.res_data  = res_q;
    assign bus.acc       = acc_q;
`ifdef ALU_FLAGS_EN
    assign bus.res_zero  = zero_q;
    assign bus.res_neg   = neg_q;
`endif
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed plus randomized bench for alu_cmd_sequencer (ALU_LAT=1 and ALU_LAT=4 instances).
// The bench plays the ALU and checks against an opcode-level reference model.
module tb_alu_cmd_sequencer;
    localparam int unsigned W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [W-1:0] m_acc1;

    alu_cmd_sequencer_if #(.WIDTH(W)) if1 ();
    alu_cmd_sequencer_if #(.WIDTH(W)) if4 ();

    alu_cmd_sequencer #(.WIDTH(W), .ALU_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    alu_cmd_sequencer #(.WIDTH(W), .ALU_LAT(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU driven by the one-hot select; junk when nothing is selected.
    function automatic logic [W-1:0] alu_fn(input logic [11:0] sel, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (sel)
            12'h001: alu_fn = a & b;
            12'h002: alu_fn = a | b;
            12'h004: alu_fn = ~a;
            12'h008: alu_fn = a ^ b;
            12'h010: alu_fn = ~(a & b);
            12'h020: alu_fn = ~(a | b);
            12'h040: alu_fn = ~(a ^ b);
            12'h080: alu_fn = a + b;
            12'h100: alu_fn = a - b;
            12'h200: alu_fn = a >> b[3:0];
            12'h400: alu_fn = a << b[3:0];
            default: alu_fn = 16'hDEAD;
        endcase
    endfunction

    always_comb if1.alu_result = alu_fn(if1.alu_sel, if1.alu_a, if1.alu_b);
    always_comb if4.alu_result = alu_fn(if4.alu_sel, if4.alu_a, if4.alu_b);

    // Reference model in opcode terms.
    function automatic logic [W-1:0] ref_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            4'd0:    ref_res = a & b;
            4'd1:    ref_res = a | b;
            4'd2:    ref_res = ~a;
            4'd3:    ref_res = a ^ b;
            4'd4:    ref_res = ~(a & b);
            4'd5:    ref_res = ~(a | b);
            4'd6:    ref_res = ~(a ^ b);
            4'd8:    ref_res = a + b;
            4'd9:    ref_res = a - b;
            4'd10:   ref_res = a >> b[3:0];
            4'd11:   ref_res = a << b[3:0];
            default: ref_res = '0;
        endcase
    endfunction

    function automatic logic [11:0] ref_sel(input logic [3:0] op);
        logic [11:0] tbl [16];
        tbl = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040, 12'h800,
                12'h080, 12'h100, 12'h200, 12'h400, 12'h800, 12'h800, 12'h800, 12'h800};
        ref_sel = tbl[op];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command through the LAT=1 instance; optionally stall in DONE, or reset there.
    task automatic run1(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic use_acc, input int unsigned hold, input bit rst_in_done);
        logic [W-1:0] ea, exp;
        bit           clr;
        ea  = use_acc ? m_acc1 : a;
        clr = (ref_sel(op) == 12'h800);
        exp = clr ? '0 : ref_res(op, ea, b);
        chk("cmd_ready_idle", 32'(if1.cmd_ready), 32'd1);
        if1.cmd_valid = 1'b1; if1.cmd_op = op; if1.cmd_a = a; if1.cmd_b = b;
        if1.cmd_use_acc = use_acc;
        tick();
        if1.cmd_valid = 1'b0;
        if1.cmd_a = 16'hA5A5;
        if (!clr) begin
            chk("exec_sel", 32'(if1.alu_sel), 32'(ref_sel(op)));
            chk("exec_a", 32'(if1.alu_a), 32'(ea));
            chk("exec_b", 32'(if1.alu_b), 32'(b));
            chk("exec_no_valid", 32'(if1.res_valid), 32'd0);
            chk("exec_busy", 32'(if1.busy), 32'd1);
            tick();
        end
        m_acc1 = exp;
        chk("done_sel_zero", 32'(if1.alu_sel), 32'd0);
        for (int unsigned h = 0; h <= hold; h++) begin
            chk("done_valid", 32'(if1.res_valid), 32'd1);
            chk("done_data", 32'(if1.res_data), 32'(exp));
            chk("done_acc", 32'(if1.acc), 32'(exp));
            chk("done_not_ready", 32'(if1.cmd_ready), 32'd0);
`ifdef ALU_FLAGS_EN
            chk("res_zero", 32'(if1.res_zero), 32'(exp == '0));
            chk("res_neg", 32'(if1.res_neg), 32'(exp[W-1]));
`endif
            if (h < hold) begin
                if1.cmd_valid = 1'b1;
                if1.cmd_op = 4'($urandom_range(0, 6));
                tick();
            end
        end
        if (rst_in_done) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_sel", 32'(if1.alu_sel), 32'd0);
            chk("rst_a", 32'(if1.alu_a), 32'd0);
            chk("rst_b", 32'(if1.alu_b), 32'd0);
            chk("rst_data", 32'(if1.res_data), 32'd0);
            chk("rst_acc", 32'(if1.acc), 32'd0);
            chk("rst_valid", 32'(if1.res_valid), 32'd0);
            chk("rst_busy", 32'(if1.busy), 32'd0);
            chk("rst_ready", 32'(if1.cmd_ready), 32'd0);
            if1.cmd_valid = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            #1;
            chk("rel_ready", 32'(if1.cmd_ready), 32'd1);
            chk("rel_busy", 32'(if1.busy), 32'd0);
            m_acc1 = '0;
            tick();
        end else begin
            if1.res_ready = 1'b1;
            tick();
            if1.res_ready = 1'b0;
            if1.cmd_valid = 1'b0;
            chk("hs_valid_low", 32'(if1.res_valid), 32'd0);
            chk("hs_ready", 32'(if1.cmd_ready), 32'd1);
            chk("hs_busy", 32'(if1.busy), 32'd0);
            chk("hs_acc", 32'(if1.acc), 32'(exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0; m_acc1 = '0;
        rst = 1'b1;
        if1.cmd_valid = 1'b0; if1.cmd_op = '0; if1.cmd_a = '0; if1.cmd_b = '0;
        if1.cmd_use_acc = 1'b0; if1.res_ready = 1'b0;
        if4.cmd_valid = 1'b0; if4.cmd_op = '0; if4.cmd_a = '0; if4.cmd_b = '0;
        if4.cmd_use_acc = 1'b0; if4.res_ready = 1'b0;
        #12;
        chk("por_acc", 32'(if1.acc), 32'd0);
        chk("por_valid", 32'(if1.res_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("por_ready", 32'(if1.cmd_ready), 32'd1);
        chk("por_busy", 32'(if1.busy), 32'd0);

        run1(4'b1000, 16'h0003, 16'h0004, 1'b0, 0, 1'b0);   // ADD 3+4
        run1(4'b1001, 16'hFFFF, 16'h0002, 1'b1, 0, 1'b0);   // SUB acc-2
        run1(4'b1111, 16'h1234, 16'h5678, 1'b0, 0, 1'b0);   // CLEAR
        run1(4'b0111, 16'h1234, 16'h5678, 1'b0, 0, 1'b0);   // CLEAR alias
        run1(4'b0011, 16'hF0F0, 16'h0FF0, 1'b0, 5, 1'b0);   // XOR, stalled result
        run1(4'b1000, 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);   // ADD into MSB
        run1(4'b1000, 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);   // ADD wrap to zero
        for (int unsigned i = 0; i < 30; i++)
            run1(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'b0);
        run1(4'b0001, 16'h00C0, 16'h0003, 1'b0, 1, 1'b1);   // reset mid-cycle while in DONE

        // LAT=4 instance: latency, then reset during EXEC.
        if4.cmd_valid = 1'b1; if4.cmd_op = 4'b1000; if4.cmd_a = 16'd5; if4.cmd_b = 16'd6;
        tick();
        if4.cmd_valid = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            chk("l4_sel", 32'(if4.alu_sel), 32'h080);
            chk("l4_no_valid", 32'(if4.res_valid), 32'd0);
            tick();
        end
        chk("l4_valid", 32'(if4.res_valid), 32'd1);
        chk("l4_data", 32'(if4.res_data), 32'd11);
        if4.res_ready = 1'b1;
        tick();
        if4.res_ready = 1'b0;
        chk("l4_idle", 32'(if4.cmd_ready), 32'd1);

        if4.cmd_valid = 1'b1; if4.cmd_op = 4'b0001; if4.cmd_a = 16'h0F00; if4.cmd_b = 16'h00F0;
        tick();
        if4.cmd_valid = 1'b0;
        chk("l4_exec1_acc", 32'(if4.acc), 32'd11);
        tick();
        chk("l4_exec2_sel", 32'(if4.alu_sel), 32'h002);
        #2 rst = 1'b1;
        #1;
        chk("l4_rst_sel", 32'(if4.alu_sel), 32'd0);
        chk("l4_rst_acc", 32'(if4.acc), 32'd0);
        chk("l4_rst_busy", 32'(if4.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            tick();
            chk("l4_never_valid", 32'(if4.res_valid), 32'd0);
            chk("l4_stay_idle", 32'(if4.busy), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
